key_entry_frontend: RTL
=======================

Name: key_entry_frontend

Overview:
Upstream input stage for the digital lock FSM. Takes raw mechanical button lines (digit-0, digit-1, enter, clear) and conditions each one with synchronisation, debouncing and press detection. Collects a KEY_BITS-wide code MSB-first and hands the completed code to the lock FSM over a valid/ready handshake. It also emits per-digit strobes and flags entry errors: a short entry and an inactivity timeout.

Parameters:
KEY_BITS, 4, number of code digits per entry (≥2)
DEBOUNCE_CYCLES, 16, consecutive stable synced cycles before a debounced level changes (≥2)
TIMEOUT_CYCLES, 1000, idle cycles allowed between digits in COLLECT/FULL before the entry is abandoned

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
btn_zero_raw  in  1  asynchronous raw button, enters digit 0
btn_one_raw  in  1  asynchronous raw button, enters digit 1
btn_enter_raw  in  1  asynchronous raw button, submits the code
btn_clear_raw  in  1  asynchronous raw button, abandons the entry
code_ready  in  1  lock FSM accepts the code
code  out  KEY_BITS  assembled code, first digit in the MSB
code_valid  out  1  code is complete and submitted
key_count  out  $clog2(KEY_BITS+1)  digits held in the current entry
digit_strobe  out  1  one-cycle pulse for each accepted digit
digit_bit  out  1  value of the accepted digit; meaningful only while digit_strobe=1
short_err  out  1  one-cycle pulse: enter pressed with fewer than KEY_BITS digits
timeout_err  out  1  one-cycle pulse: entry abandoned on timeout

Behaviour:
- Reset (synchronous, active-high) takes priority over everything, including a mid-entry or mid-handshake state. It clears the sync flops, debounced levels, debounce counters, timeout counter and shift register, and sets state=IDLE. Every output is 0 during and after reset.
- Conditioning, per button:
  - 2-flop synchroniser.
  - Debounce counter resets whenever the synced value equals the debounced level; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synced value.
  - A press event is a one-cycle pulse in the cycle after the debounced level rises 0->1. There is no event on release.
  - Latency for a clean press first sampled high at edge N: event asserted in the cycle following edge N+2+DEBOUNCE_CYCLES.
  - Glitches shorter than DEBOUNCE_CYCLES produce no event.
- Same-cycle priority: clear > enter > digit.
  - zero and one events in the same cycle are both dropped: no strobe, no count change.
- FSM states: IDLE, COLLECT, FULL, HOLD.
  - IDLE: key_count=0, code=0.
    - Digit event -> shift the digit in, key_count=1, digit_strobe=1 with digit_bit=value, go to COLLECT.
    - Enter event -> short_err pulse, stay in IDLE.
    - Clear event -> no effect.
  - COLLECT:
    - Digit event -> code = {code[KEY_BITS-2:0], digit}, key_count+1, strobe.
    - When key_count becomes KEY_BITS -> FULL.
    - Enter event -> short_err pulse, clear the entry, go to IDLE.
  - FULL:
    - Digit events are ignored: no strobe, code unchanged.
    - Enter event -> code_valid=1, go to HOLD.
  - HOLD:
    - code_valid=1; code and key_count held stable.
    - All button events, including clear, are ignored.
    - Handshake completes at the clock edge where code_valid=1 and code_ready=1. Next cycle: code_valid=0, code=0, key_count=0, state=IDLE.
    - code_ready high outside HOLD has no effect.
  - Clear event in COLLECT or FULL -> code=0, key_count=0, IDLE. No error pulse.
- Timeout:
  - The counter runs only in COLLECT and FULL and reloads to 0 on every accepted digit event.
  - When it reaches TIMEOUT_CYCLES-1 without an event: timeout_err pulse, clear the entry, go to IDLE.
  - If an enter or clear event occurs in the same cycle as expiry, the event wins and timeout_err is not pulsed.
- Counter widths are sized from the parameters. Counters saturate and never wrap.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50, KEY_BITS=4.)
- Clean presses 1,0,1,0 then enter -> four digit_strobe pulses with digit_bit 1,0,1,0. key_count steps 1..4. code=4'b1010 and code_valid=1 held until code_ready; IDLE and code=0 one cycle after the handshake edge.
- btn_one_raw held high at edge N, then bounced at 2-cycle intervals for 10 cycles before settling high -> exactly one strobe, occurring 6 cycles after the edge where the line settled high.
- Digits 1,1 then enter -> short_err one-cycle pulse, key_count=0, code_valid stays 0.
- 4 digits, then a fifth digit, then enter, with code_ready held low for 20 cycles -> fifth digit produces no strobe; code stays 4'b(first four digits) and code_valid stays high for all 20 cycles; clear pressed during HOLD is ignored.
- One digit, then no input for 50 cycles -> timeout_err pulse on cycle 50, key_count=0, state IDLE.
- Reset asserted during HOLD; also clear and digit events in the same cycle during COLLECT -> reset: all outputs 0 on the next cycle; same-cycle case: entry cleared with no strobe.

Source files
------------

// File: rtl/key_entry_frontend.sv
// Key entry front end: conditions four raw buttons (sync, debounce, press
// detect), assembles a KEY_BITS-digit code MSB-first and offers it to the
// lock FSM over a valid/ready handshake, with short-entry and timeout flags.
module key_entry_frontend #(
    parameter int unsigned KEY_BITS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              btn_zero_raw,
    input  logic                              btn_one_raw,
    input  logic                              btn_enter_raw,
    input  logic                              btn_clear_raw,
    input  logic                              code_ready,
    output logic [KEY_BITS-1:0]               code,
    output logic                              code_valid,
    output logic [$clog2(KEY_BITS+1)-1:0]     key_count,
    output logic                              digit_strobe,
    output logic                              digit_bit,
    output logic                              short_err,
    output logic                              timeout_err
);

    localparam int unsigned KCW  = $clog2(KEY_BITS + 1);
    localparam int unsigned DCW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TCW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned NBTN = 4;

    typedef enum logic [1:0] {IDLE, COLLECT, FULL, HOLD} state_t;

    logic [NBTN-1:0] raw;
    logic [NBTN-1:0] sync1;
    logic [NBTN-1:0] sync2;
    logic [NBTN-1:0] level;
    logic [NBTN-1:0] press;
    logic [DCW-1:0]  dcnt [NBTN];

    state_t          state;
    logic [TCW-1:0]  tcnt;
    logic            ev_clear;
    logic            ev_enter;
    logic            digit_ev;
    logic            digit_val;
    logic            tmo_hit;
    logic [KEY_BITS-1:0] code_shift;

    // button order: 0=zero, 1=one, 2=enter, 3=clear
    assign raw = {btn_clear_raw, btn_enter_raw, btn_one_raw, btn_zero_raw};

    // Two-flop synchroniser and per-button debounce counter/level
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            for (int i = 0; i < int'(NBTN); i++) begin
                dcnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < int'(NBTN); i++) begin
                if (sync2[i] == level[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DCW'(DEBOUNCE_CYCLES)) begin
                    level[i] <= sync2[i];
                    dcnt[i]  <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + DCW'(1);
                end
            end
        end
    end

    // Press event: the debounced level is about to rise on this edge
    always_comb begin
        press = '0;
        for (int i = 0; i < int'(NBTN); i++) begin
            press[i] = sync2[i] & ~level[i] & (dcnt[i] == DCW'(DEBOUNCE_CYCLES));
        end
    end

    // simultaneous zero and one cancel each other
    assign ev_clear   = press[3];
    assign ev_enter   = press[2];
    assign digit_ev   = press[0] ^ press[1];
    assign digit_val  = press[1];
    assign tmo_hit    = (tcnt == TCW'(TIMEOUT_CYCLES - 1));
    assign code_shift = {code[KEY_BITS-2:0], digit_val};

    // Entry FSM with registered outputs; priority clear > enter > digit > timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            code         <= '0;
            key_count    <= '0;
            code_valid   <= 1'b0;
            digit_strobe <= 1'b0;
            digit_bit    <= 1'b0;
            short_err    <= 1'b0;
            timeout_err  <= 1'b0;
            tcnt         <= '0;
        end else begin
            digit_strobe <= 1'b0;
            digit_bit    <= 1'b0;
            short_err    <= 1'b0;
            timeout_err  <= 1'b0;
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (!ev_clear) begin
                        if (ev_enter) begin
                            short_err <= 1'b1;
                        end else if (digit_ev) begin
                            code         <= KEY_BITS'(digit_val);
                            key_count    <= KCW'(1);
                            digit_strobe <= 1'b1;
                            digit_bit    <= digit_val;
                            state        <= COLLECT;
                        end
                    end
                end
                COLLECT, FULL: begin
                    if (ev_clear) begin
                        code      <= '0;
                        key_count <= '0;
                        tcnt      <= '0;
                        state     <= IDLE;
                    end else if (ev_enter) begin
                        tcnt <= '0;
                        if (state == FULL) begin
                            code_valid <= 1'b1;
                            state      <= HOLD;
                        end else begin
                            short_err <= 1'b1;
                            code      <= '0;
                            key_count <= '0;
                            state     <= IDLE;
                        end
                    end else if (digit_ev && state == COLLECT) begin
                        code         <= code_shift;
                        key_count    <= key_count + KCW'(1);
                        digit_strobe <= 1'b1;
                        digit_bit    <= digit_val;
                        tcnt         <= '0;
                        if (key_count == KCW'(KEY_BITS - 1)) begin
                            state <= FULL;
                        end
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        code        <= '0;
                        key_count   <= '0;
                        tcnt        <= '0;
                        state       <= IDLE;
                    end else begin
                        tcnt <= tcnt + TCW'(1);
                    end
                end
                HOLD: begin
                    tcnt <= '0;
                    if (code_ready) begin
                        code_valid <= 1'b0;
                        code       <= '0;
                        key_count  <= '0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
